// File: rtl/rowbuf_window_ctrl.sv
// Row-buffer sequencer: turns a raster pixel stream into a vertically aligned NUM_ROWS pixel column.
// Optional line-length consistency check enabled by defining ROWBUF_WINDOW_CTRL_LEN_CHECK_EN.
module rowbuf_window_ctrl #(
    parameter int PIXEL_WIDTH = 10,
    parameter int MAX_COLS    = 1288,
    parameter int NUM_ROWS    = 3,
    parameter int ADDR_WIDTH  = $clog2(MAX_COLS),
    parameter int ROW_WIDTH   = 12
) (
    input  logic                            clk,
    input  logic                            resetb,
    input  logic                            fv,
    input  logic                            lv,
    input  logic                            dvi,
    input  logic [PIXEL_WIDTH-1:0]          datai,
    output logic                            dvo,
    output logic [NUM_ROWS*PIXEL_WIDTH-1:0] col_o,
    output logic [ADDR_WIDTH-1:0]           col_pos,
    output logic [ROW_WIDTH-1:0]            row_pos,
    output logic                            window_valid,
    output logic                            overflow
`ifdef ROWBUF_WINDOW_CTRL_LEN_CHECK_EN
    ,
    output logic                            len_err
`endif
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int PTR_W = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HBLANK = 2'd1,
        S_LINE   = 2'd2
    } state_t;

    state_t                            state_r, state_s;
    logic                              frame_start_s, accept_s, eol_s, wr_s, line_done_s;
    logic [CNT_W-1:0]                  col_cnt_r;
    logic [ADDR_WIDTH-1:0]             col_addr_s;
    logic [ROW_WIDTH-1:0]              row_r;
    logic [PTR_W-1:0]                  wptr_r, filled_r;
    logic                              overflow_r;
    logic [PIXEL_WIDTH-1:0]            mem_r [NUM_ROWS][MAX_COLS];
    logic [NUM_ROWS*PIXEL_WIDTH-1:0]   lanes_s;
    logic                              dvo_r, window_valid_r;
    logic [NUM_ROWS*PIXEL_WIDTH-1:0]   col_o_r;
    logic [ADDR_WIDTH-1:0]             col_pos_r;
    logic [ROW_WIDTH-1:0]              row_pos_r;

    // Buffer holding the line written k lines before the current write buffer
    function automatic logic [PTR_W-1:0] rd_idx(input logic [PTR_W-1:0] ptr, input int k);
        int t;
        t = (int'(ptr) + NUM_ROWS - k) % NUM_ROWS;
        return PTR_W'(t);
    endfunction

    assign col_addr_s  = col_cnt_r[ADDR_WIDTH-1:0];
    assign wr_s        = accept_s && (col_cnt_r < CNT_W'(MAX_COLS));
    assign line_done_s = eol_s && (col_cnt_r != CNT_W'(0));

    // State register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and per-cycle control strobes; fv low forces idle with no bookkeeping
    always_comb begin
        state_s       = state_r;
        frame_start_s = 1'b0;
        accept_s      = 1'b0;
        eol_s         = 1'b0;
        if (!fv) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_s       = S_HBLANK;
                    frame_start_s = 1'b1;
                end
                S_HBLANK: begin
                    accept_s = lv & dvi;
                    if (lv) begin
                        state_s = S_LINE;
                    end else begin
                        state_s = S_HBLANK;
                    end
                end
                S_LINE: begin
                    accept_s = lv & dvi;
                    if (!lv) begin
                        state_s = S_HBLANK;
                        eol_s   = 1'b1;
                    end else begin
                        state_s = S_LINE;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // Position counters, write-buffer rotation and overflow flag
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            col_cnt_r  <= CNT_W'(0);
            row_r      <= ROW_WIDTH'(0);
            wptr_r     <= PTR_W'(0);
            filled_r   <= PTR_W'(0);
            overflow_r <= 1'b0;
        end else if (frame_start_s) begin
            col_cnt_r  <= CNT_W'(0);
            row_r      <= ROW_WIDTH'(0);
            wptr_r     <= PTR_W'(0);
            filled_r   <= PTR_W'(0);
            overflow_r <= 1'b0;
        end else if (line_done_s) begin
            col_cnt_r <= CNT_W'(0);
            row_r     <= row_r + ROW_WIDTH'(1);
            wptr_r    <= (wptr_r == PTR_W'(NUM_ROWS - 1)) ? PTR_W'(0) : wptr_r + PTR_W'(1);
            if (filled_r != PTR_W'(NUM_ROWS - 1)) begin
                filled_r <= filled_r + PTR_W'(1);
            end
        end else if (accept_s) begin
            if (wr_s) begin
                col_cnt_r <= col_cnt_r + CNT_W'(1);
            end else begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Row buffer storage; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wptr_r][col_addr_s] <= datai;
        end
    end

    // Column assembly: old buffer contents read in the same cycle as the write
    always_comb begin
        lanes_s                  = '0;
        lanes_s[0 +: PIXEL_WIDTH] = datai;
        for (int k = 1; k < NUM_ROWS; k++) begin
            if (k <= int'(filled_r)) begin
                lanes_s[k*PIXEL_WIDTH +: PIXEL_WIDTH] = mem_r[rd_idx(wptr_r, k)][col_addr_s];
            end else begin
                lanes_s[k*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
            end
        end
    end

    // Registered outputs; column data and positions hold between strobes
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            dvo_r          <= 1'b0;
            col_o_r        <= '0;
            col_pos_r      <= ADDR_WIDTH'(0);
            row_pos_r      <= ROW_WIDTH'(0);
            window_valid_r <= 1'b0;
        end else begin
            dvo_r <= wr_s;
            if (wr_s) begin
                col_o_r        <= lanes_s;
                col_pos_r      <= col_addr_s;
                row_pos_r      <= row_r;
                window_valid_r <= (filled_r == PTR_W'(NUM_ROWS - 1));
            end
        end
    end

    assign dvo          = dvo_r;
    assign col_o        = col_o_r;
    assign col_pos      = col_pos_r;
    assign row_pos      = row_pos_r;
    assign window_valid = window_valid_r;
    assign overflow     = overflow_r;

`ifdef ROWBUF_WINDOW_CTRL_LEN_CHECK_EN
    logic [CNT_W-1:0] len_r;
    logic             len_set_r, len_err_r;

    // First completed line of a frame sets the reference length for the rest
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            len_r     <= CNT_W'(0);
            len_set_r <= 1'b0;
            len_err_r <= 1'b0;
        end else if (frame_start_s) begin
            len_r     <= CNT_W'(0);
            len_set_r <= 1'b0;
            len_err_r <= 1'b0;
        end else if (line_done_s) begin
            if (!len_set_r) begin
                len_r     <= col_cnt_r;
                len_set_r <= 1'b1;
            end else if (col_cnt_r != len_r) begin
                len_err_r <= 1'b1;
            end
        end
    end

    assign len_err = len_err_r;
`endif

endmodule
